// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM sequencing controller: FSM states,
// datapath mux selects, opcodes, condition codes and the main-FSM control bundle.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned FLAG_W  = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Raw per-state signals from the main FSM, before condition gating.
  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } fsm_ctl_t;

  // Condition-code evaluation against the architectural {N,Z,C,V}; 1111 never executes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [FLAG_W-1:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    res = 1'b0;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle: instruction fields and ALU flags in,
// write enables and mux selects out.
interface mc_if;
  import mc_pkg::*;

  logic [INSTR_W-1:0] Instr;
  logic [FLAG_W-1:0]  ALUFlags;
  logic               PCWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         RegSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [1:0]         ImmSrc;
  logic [1:0]         ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

endinterface

// File: rtl/mc_mainfsm.sv
// Moore main FSM of the multicycle controller: state register, next-state
// selection from Op/Funct and the raw per-state control bundle.
module mc_mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       funct5,
  input  logic       funct0,
  output state_t     state,
  output fsm_ctl_t   ctl
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs; everything not named in a state stays 0.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        state_d       = S_DECODE;
        ctl.irwrite   = 1'b1;
        ctl.nextpc    = 1'b1;
        ctl.alusrca   = SRCA_PC;
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ctl.alusrca   = SRCA_PC;
        ctl.alusrcb   = SRCB_FOUR;
        ctl.resultsrc = RES_ALURESULT;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct5 ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d     = funct0 ? S_MEMREAD : S_MEMWRITE;
        ctl.alusrca = SRCA_REG;
        ctl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_d       = S_MEMWB;
        ctl.adrsrc    = 1'b1;
        ctl.resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        state_d       = S_FETCH;
        ctl.resultsrc = RES_DATA;
        ctl.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        state_d       = S_FETCH;
        ctl.adrsrc    = 1'b1;
        ctl.resultsrc = RES_ALUOUT;
        ctl.memw      = 1'b1;
      end
      S_EXECUTER: begin
        state_d     = S_ALUWB;
        ctl.alusrca = SRCA_REG;
        ctl.alusrcb = SRCB_WD;
        ctl.aluop   = 1'b1;
      end
      S_EXECUTEI: begin
        state_d     = S_ALUWB;
        ctl.alusrca = SRCA_REG;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = 1'b1;
      end
      S_ALUWB: begin
        state_d       = S_FETCH;
        ctl.resultsrc = RES_ALUOUT;
        ctl.regw      = 1'b1;
      end
      S_BRANCH: begin
        state_d       = S_FETCH;
        ctl.alusrca   = SRCA_REG;
        ctl.alusrcb   = SRCB_IMM;
        ctl.resultsrc = RES_ALURESULT;
        ctl.branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM sequencing controller: main FSM plus ALU decode, PC-source
// logic, condition check, NZCV flags and the latched condition result.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  state_t   state;
  fsm_ctl_t ctl;

  mc_mainfsm u_fsm (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .funct5 (funct[5]),
    .funct0 (funct[0]),
    .state  (state),
    .ctl    (ctl)
  );

  logic [1:0] alucontrol;
  logic [1:0] flagw;
  logic       cmd_valid;
  logic       cmd_arith;

  // ALU decode; unrecognised commands fall back to ADD and never touch flags.
  always_comb begin
    alucontrol = ALU_ADD;
    cmd_valid  = 1'b0;
    cmd_arith  = 1'b0;
    if (ctl.aluop) begin
      case (funct[4:1])
        4'b0100: begin alucontrol = ALU_ADD; cmd_valid = 1'b1; cmd_arith = 1'b1; end
        4'b0010: begin alucontrol = ALU_SUB; cmd_valid = 1'b1; cmd_arith = 1'b1; end
        4'b0000: begin alucontrol = ALU_AND; cmd_valid = 1'b1; end
        4'b1100: begin alucontrol = ALU_ORR; cmd_valid = 1'b1; end
        default: alucontrol = ALU_ADD;
      endcase
    end
  end

  assign flagw = {funct[0] & cmd_valid, funct[0] & cmd_valid & cmd_arith};

  logic             pcs;
  logic             condex;
  logic             condexreg;
  logic [FLAG_W-1:0] flags;

  assign pcs    = ((rd == 4'd15) & ctl.regw) | ctl.branch;
  assign condex = cond_check(cond, flags);

  // Condition result is frozen at DECODE so later flag updates cannot affect this instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                condexreg <= 1'b0;
    else if (state == S_DECODE) condexreg <= condex;
  end

  // flagw is only non-zero while aluop is high, i.e. in the execute states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else begin
      if (flagw[1] & condexreg) flags[3:2] <= bus.ALUFlags[3:2];
      if (flagw[0] & condexreg) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.PCWrite    = ctl.nextpc | (pcs & condexreg);
  assign bus.RegWrite   = ctl.regw & condexreg;
  assign bus.MemWrite   = ctl.memw & condexreg;
  assign bus.IRWrite    = ctl.irwrite;
  assign bus.AdrSrc     = ctl.adrsrc;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.ALUSrcA    = ctl.alusrca;
  assign bus.ALUSrcB    = ctl.alusrcb;
  assign bus.ResultSrc  = ctl.resultsrc;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alucontrol;

endmodule

// File: doc/mc_controller.md
# mc_controller

Sequencing controller for the multicycle ARM datapath. It decodes the fetched instruction and steps a Moore main FSM through fetch, decode, execute, memory and writeback. It holds the architectural NZCV flags and evaluates condition codes, and it drives every datapath control input (PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA/B, ResultSrc, ImmSrc, ALUControl) plus MemWrite to memory. It sits beside the datapath inside the processor top level.

## Interface
- No parameters (instruction width fixed at 32).
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-low: asserted when 0; deassertion is synchronised by the top level.
- `Instr` in 20 — Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- `ALUFlags` in 4 — {N,Z,C,V} from the datapath ALU, same cycle.
- `PCWrite`, `RegWrite`, `MemWrite`, `IRWrite` out 1 each — write enables.
- `AdrSrc` out 1 — 0 = PC, 1 = ALUOut.
- `RegSrc` out 2 — [0] = (Op==10), [1] = (Op==01).
- `ALUSrcA` out 2 — 00 = A, 01 = PC; 1x is reserved, never driven.
- `ALUSrcB` out 2 — 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2 — 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc` out 2 — equals Op.
- `ALUControl` out 2 — 00 ADD, 01 SUB, 10 AND, 11 ORR.

## Operation
- **FSM states:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE→MEMADR (Op 01); EXECUTEI (Op 00, Funct[5]=1); EXECUTER (Op 00, Funct[5]=0); BRANCH (Op 10); FETCH (Op 11, undefined, executes as NOP).
  - MEMADR→MEMREAD (Funct[0]=1) else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - BRANCH→FETCH.
- **Per-state FSM signals** (unlisted = 0):
  - FETCH: IRWrite, NextPC, AdrSrc 0, ALUSrcA 01, ALUSrcB 10, ResultSrc 10.
  - DECODE: ALUSrcA 01, ALUSrcB 10, ResultSrc 10.
  - MEMADR: ALUSrcA 00, ALUSrcB 01.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegW.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemW.
  - EXECUTER: ALUSrcA 00, ALUSrcB 00, ALUOp.
  - EXECUTEI: ALUSrcA 00, ALUSrcB 01, ALUOp.
  - ALUWB: ResultSrc 00, RegW.
  - BRANCH: ALUSrcA 00, ALUSrcB 01, ResultSrc 10, Branch.
- **ALU decode:**
  - With ALUOp=0: ALUControl=00, FlagW=00.
  - With ALUOp=1, Funct[4:1] selects: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR; any other value→00 with FlagW=00.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ADD|SUB).
- **PC source:** PCS = (Rd==15 & RegW) | Branch.
- **Conditions:**
  - CondEx is computed from the flags register and Cond: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Cond 1111 gives CondEx=0.
  - CondExReg loads CondEx at the DECODE edge only.
- **Gated outputs:**
  - PCWrite = NextPC | (PCS & CondExReg).
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
- **Flags:**
  - N,Z load ALUFlags[3:2] when FlagW[1] & CondExReg.
  - C,V load ALUFlags[1:0] when FlagW[0] & CondExReg.
  - Flags change only at the EXECUTER/EXECUTEI edge.

## Timing
- **Reset values:** state=FETCH, flags=0000, CondExReg=0. Outputs show FETCH decode (PCWrite=1, IRWrite=1); the datapath is held in reset by the same signal.
- **Reset mid-instruction:** returns immediately to FETCH, discards the instruction, clears the flags.
- **Outputs:** combinational from state, registered CondExReg and Instr; no output registers.
- **Cycles per instruction:** LDR 5, STR 4, data-processing 4, branch 3, undefined 2. A failed condition spends the same cycle count with all writes suppressed, except the FETCH PC increment.
- A flag-setting instruction's new flags affect only the next instruction's CondEx, never its own writeback.

## Structure
- **Package `mc_pkg`:**
  - state enum (4-bit encoding);
  - ALUControl, ResultSrc, ALUSrcA/B encodings;
  - Op codes and condition-code constants.
- **Sub-module `mc_mainfsm`:** state register, next-state logic and per-state signals.
- **In `mc_controller`:** ALU decode, PCS, condition check, flag and CondExReg registers.

## Test plan
- **Reset:** hold reset=0 mid-MEMREAD, release → state FETCH, PCWrite=1, IRWrite=1, flags 0000.
- **ADD R1,R2,R3:** Instr 0xE0821 → FETCH, DECODE, EXECUTER (ALUControl 00, ALUSrcB 00), ALUWB (RegWrite=1, ResultSrc 00), 4 cycles, flags unchanged.
- **SUBS R1,R2,#5:** Instr 0xE2521, ALUFlags 0110 in EXECUTEI → flags become 0110, RegWrite=1 in ALUWB.
- **LDR R1,[R2,#4]:** Instr 0xE5921 → MEMREAD AdrSrc=1, MEMWB ResultSrc 01 RegWrite=1.
- **STR:** Instr 0xE5821 → MEMWRITE MemWrite=1 and RegWrite=0 throughout.
- **BEQ:** Instr 0x0A000 with Z=0 → BRANCH PCWrite=0; with Z=1 → PCWrite=1, ResultSrc 10.
